// File: rtl/tnet_cmd_pkg.sv
// rtl/tnet_cmd_pkg.sv - shared types and bit positions for the TNET command dispatcher
package tnet_cmd_pkg;

   typedef struct packed {
      logic [4:0]  op;
      logic [15:0] addr;
      logic [15:0] len;
      logic [95:0] dt;
   } tnet_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } tnet_state_e;

   localparam int STS_BUSY      = 0;
   localparam int STS_EMPTY     = 1;
   localparam int STS_FULL      = 2;
   localparam int STS_CNT_LSB   = 3;
   localparam int STS_CNT_MSB   = 6;
   localparam int STS_OVF       = 8;
   localparam int STS_ERR       = 9;
   localparam int STS_TO        = 10;
   localparam int STS_BAD_OP    = 11;
   localparam int STS_STATE_LSB = 12;
   localparam int STS_STATE_MSB = 13;
   localparam int STS_DONE_LSB  = 16;
   localparam int STS_DONE_MSB  = 31;

   localparam int CTRL_EXEC   = 0;
   localparam int CTRL_OP_LSB = 1;
   localparam int CTRL_OP_MSB = 5;
   localparam int CTRL_CLR    = 7;

endpackage

// File: rtl/tnet_cmd_fifo.sv
// rtl/tnet_cmd_fifo.sv - synchronous command FIFO; a push is accepted when full if a pop
// happens in the same cycle
module tnet_cmd_fifo
   import tnet_cmd_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          push_i,
   input  tnet_cmd_t     wdata_i,
   input  logic          pop_i,
   output tnet_cmd_t     rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o
);

   tnet_cmd_t     mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic [AW:0]   count_d;
   logic          push_ok;
   logic          pop_ok;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + (AW+1)'(1);
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/tnet_cmd_dispatch.sv
// rtl/tnet_cmd_dispatch.sv - queues TNET_CTRL exec writes and issues them to the core one at a time
// Optional completion timeout built when TNET_CMD_TIMEOUT_EN is defined.
module tnet_cmd_dispatch
   import tnet_cmd_pkg::*;
#(
   parameter int CMD_DEPTH = 4,
   parameter int TO_W      = 16
) (
   input  logic        ps_aclk,
   input  logic        ps_aresetn,
   input  logic [31:0] TNET_CTRL,
   input  logic [31:0] TNET_CFG,
   input  logic [15:0] TNET_ADDR,
   input  logic [15:0] TNET_LEN,
   input  logic [31:0] RAXI_DT1,
   input  logic [31:0] RAXI_DT2,
   input  logic [31:0] RAXI_DT3,
   output logic        cmd_valid_o,
   input  logic        cmd_ready_i,
   output logic [4:0]  cmd_op_o,
   output logic [15:0] cmd_addr_o,
   output logic [15:0] cmd_len_o,
   output logic [95:0] cmd_dt_o,
   input  logic        cmd_done_i,
   input  logic        cmd_err_i,
   output logic [31:0] CMD_STATUS
);

   localparam int AW = $clog2(CMD_DEPTH);

   tnet_state_e state_q, state_d;
   tnet_cmd_t   cap_q;
   tnet_cmd_t   out_q;
   tnet_cmd_t   fifo_rdata;
   logic        exec_q, exec_prev_q;
   logic        clr_q, clr_prev_q;
   logic        exec_ev, clr_ev, op_zero;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [AW:0] fifo_count;
   logic        ovf_q, err_q, bad_q, to_q;
   logic        ovf_d, err_d, bad_d;
   logic        ovf_set, bad_set, err_set, to_set, done_evt, to_expire;
   logic [15:0] done_cnt_q;
   logic [31:0] status;
   logic        unused_bits;

   // Fields are captured alongside CTRL so a push uses one coherent snapshot.
   always_ff @(posedge ps_aclk) begin
      if (!ps_aresetn) begin
         cap_q       <= '0;
         exec_q      <= 1'b0;
         exec_prev_q <= 1'b0;
         clr_q       <= 1'b0;
         clr_prev_q  <= 1'b0;
      end else begin
         cap_q       <= '{op: TNET_CTRL[CTRL_OP_MSB:CTRL_OP_LSB], addr: TNET_ADDR, len: TNET_LEN,
                          dt: {RAXI_DT3, RAXI_DT2, RAXI_DT1}};
         exec_q      <= TNET_CTRL[CTRL_EXEC];
         exec_prev_q <= exec_q;
         clr_q       <= TNET_CTRL[CTRL_CLR];
         clr_prev_q  <= clr_q;
      end
   end

   assign exec_ev   = exec_q && !exec_prev_q;
   assign clr_ev    = clr_q && !clr_prev_q;
   assign op_zero   = (cap_q.op == 5'd0);
   assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
   assign fifo_push = exec_ev && !op_zero;
   assign ovf_set   = fifo_push && fifo_full && !fifo_pop;
   assign bad_set   = exec_ev && op_zero;

   tnet_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
      .clk_i   (ps_aclk),
      .rstn_i  (ps_aresetn),
      .push_i  (fifo_push),
      .wdata_i (cap_q),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d  = state_q;
      done_evt = 1'b0;
      err_set  = 1'b0;
      to_set   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (cmd_ready_i) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cmd_done_i) begin
               state_d  = ST_IDLE;
               done_evt = 1'b1;
               err_set  = cmd_err_i;
            end else if (to_expire) begin
               state_d = ST_IDLE;
               to_set  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A set in the same cycle as a clear rise wins.
   assign ovf_d = ovf_set || (ovf_q && !clr_ev);
   assign err_d = err_set || (err_q && !clr_ev);
   assign bad_d = bad_set || (bad_q && !clr_ev);

   always_ff @(posedge ps_aclk) begin
      if (!ps_aresetn) begin
         state_q    <= ST_IDLE;
         out_q      <= '0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
         bad_q      <= 1'b0;
         done_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (fifo_pop) begin
            out_q <= fifo_rdata;
         end
         ovf_q <= ovf_d;
         err_q <= err_d;
         bad_q <= bad_d;
         if (done_evt) begin
            done_cnt_q <= done_cnt_q + 16'd1;
         end
      end
   end

`ifdef TNET_CMD_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt_q;

   // A loaded value of zero never reaches one, so the timeout stays disabled.
   assign to_expire = (state_q == ST_WAIT) && (to_cnt_q == TO_W'(1));

   always_ff @(posedge ps_aclk) begin
      if (!ps_aresetn) begin
         to_cnt_q <= '0;
         to_q     <= 1'b0;
      end else begin
         if (state_q == ST_ISSUE && cmd_ready_i) begin
            to_cnt_q <= TNET_CFG[TO_W-1:0];
         end else if (state_q == ST_WAIT && to_cnt_q != '0) begin
            to_cnt_q <= to_cnt_q - TO_W'(1);
         end
         to_q <= to_set || (to_q && !clr_ev);
      end
   end

   assign unused_bits = ^{TNET_CTRL[31:8], TNET_CTRL[6], TNET_CFG};
`else
   localparam int unused_to_w = TO_W;

   assign to_expire   = 1'b0;
   assign to_q        = 1'b0;
   assign unused_bits = ^{TNET_CTRL[31:8], TNET_CTRL[6], TNET_CFG, to_set};
`endif

   always_comb begin
      status                              = '0;
      status[STS_BUSY]                    = (state_q != ST_IDLE);
      status[STS_EMPTY]                   = fifo_empty;
      status[STS_FULL]                    = fifo_full;
      status[STS_CNT_MSB:STS_CNT_LSB]     = 4'(fifo_count);
      status[STS_OVF]                     = ovf_q;
      status[STS_ERR]                     = err_q;
      status[STS_TO]                      = to_q;
      status[STS_BAD_OP]                  = bad_q;
      status[STS_STATE_MSB:STS_STATE_LSB] = state_q;
      status[STS_DONE_MSB:STS_DONE_LSB]   = done_cnt_q;
   end

   assign CMD_STATUS  = status;
   assign cmd_valid_o = (state_q == ST_ISSUE);
   assign cmd_op_o    = out_q.op;
   assign cmd_addr_o  = out_q.addr;
   assign cmd_len_o   = out_q.len;
   assign cmd_dt_o    = out_q.dt;

endmodule

// File: tb/tb_tnet_cmd_dispatch.sv
// tb/tb_tnet_cmd_dispatch.sv - randomized and directed checks of tnet_cmd_dispatch against a queue model
module tb_tnet_cmd_dispatch;

   localparam int DEPTH = 4;
`ifdef TNET_CMD_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        ps_aclk;
   logic        ps_aresetn;
   logic [31:0] TNET_CTRL, TNET_CFG;
   logic [15:0] TNET_ADDR, TNET_LEN;
   logic [31:0] RAXI_DT1, RAXI_DT2, RAXI_DT3;
   logic        cmd_valid_o, cmd_ready_i, cmd_done_i, cmd_err_i;
   logic [4:0]  cmd_op_o;
   logic [15:0] cmd_addr_o, cmd_len_o;
   logic [95:0] cmd_dt_o;
   logic [31:0] CMD_STATUS;

   tnet_cmd_dispatch #(.CMD_DEPTH(DEPTH), .TO_W(16)) dut (
      .ps_aclk     (ps_aclk),
      .ps_aresetn  (ps_aresetn),
      .TNET_CTRL   (TNET_CTRL),
      .TNET_CFG    (TNET_CFG),
      .TNET_ADDR   (TNET_ADDR),
      .TNET_LEN    (TNET_LEN),
      .RAXI_DT1    (RAXI_DT1),
      .RAXI_DT2    (RAXI_DT2),
      .RAXI_DT3    (RAXI_DT3),
      .cmd_valid_o (cmd_valid_o),
      .cmd_ready_i (cmd_ready_i),
      .cmd_op_o    (cmd_op_o),
      .cmd_addr_o  (cmd_addr_o),
      .cmd_len_o   (cmd_len_o),
      .cmd_dt_o    (cmd_dt_o),
      .cmd_done_i  (cmd_done_i),
      .cmd_err_i   (cmd_err_i),
      .CMD_STATUS  (CMD_STATUS)
   );

   initial ps_aclk = 1'b0;
   always #5 ps_aclk = ~ps_aclk;

   int vectors = 0;
   int miscompares = 0;
   bit cmp_on = 1'b0;
   int dc;
   logic [31:0] rv;

   task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model: pending commands in a queue, one command in service described by a phase
   // (0 idle, 1 offered, 2 awaiting completion) and the cycles spent awaiting it.
   bit [31:0]  h1, h2;
   bit [132:0] m_cap, m_cur;
   bit [132:0] mq[$];
   int         m_phase;
   bit         m_ovf, m_err, m_to, m_bad;
   bit [15:0]  m_done;
   int         m_limit, m_elapsed;

   task automatic model_step();
      bit ex, cl, ovf_s, err_s, to_s, bad_s;
      if (!ps_aresetn) begin
         mq.delete();
         m_phase = 0; m_cur = '0; m_cap = '0; h1 = '0; h2 = '0;
         m_ovf = 0; m_err = 0; m_to = 0; m_bad = 0; m_done = '0;
         m_limit = 0; m_elapsed = 0;
         return;
      end
      ex = h1[0] && !h2[0];
      cl = h1[7] && !h2[7];
      ovf_s = 0; err_s = 0; to_s = 0; bad_s = 0;
      case (m_phase)
         0: if (mq.size() > 0) begin
               m_cur = mq.pop_front();
               m_phase = 1;
            end
         1: if (cmd_ready_i) begin
               m_phase = 2;
               m_limit = int'(TNET_CFG[15:0]);
               m_elapsed = 0;
            end
         default: begin
            m_elapsed++;
            if (cmd_done_i) begin
               m_done++;
               err_s = cmd_err_i;
               m_phase = 0;
            end else if (TO_EN && m_limit != 0 && m_elapsed == m_limit) begin
               to_s = 1;
               m_phase = 0;
            end
         end
      endcase
      if (ex) begin
         if (m_cap[132:128] == 5'd0) bad_s = 1;
         else if (mq.size() < DEPTH) mq.push_back(m_cap);
         else ovf_s = 1;
      end
      m_ovf = ovf_s || (m_ovf && !cl);
      m_err = err_s || (m_err && !cl);
      m_to  = to_s  || (m_to  && !cl);
      m_bad = bad_s || (m_bad && !cl);
      h2 = h1;
      h1 = TNET_CTRL;
      m_cap = {TNET_CTRL[5:1], TNET_ADDR, TNET_LEN, RAXI_DT3, RAXI_DT2, RAXI_DT1};
   endtask

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s = '0;
      s[0]     = (m_phase != 0);
      s[1]     = (mq.size() == 0);
      s[2]     = (mq.size() == DEPTH);
      s[6:3]   = 4'(mq.size());
      s[8]     = m_ovf;
      s[9]     = m_err;
      s[10]    = m_to;
      s[11]    = m_bad;
      s[13:12] = 2'(m_phase);
      s[31:16] = m_done;
      return s;
   endfunction

   initial forever begin
      @(posedge ps_aclk);
      model_step();
   end

   initial forever begin
      @(negedge ps_aclk);
      if (cmp_on) begin
         chk("valid", 133'(cmd_valid_o), 133'(m_phase == 1));
         if (m_phase == 1)
            chk("fields", {cmd_op_o, cmd_addr_o, cmd_len_o, cmd_dt_o}, m_cur);
         chk("status", 133'(CMD_STATUS), 133'(model_status()));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge ps_aclk);
   endtask

   task automatic do_exec(input logic [31:0] ctrl);
      TNET_CTRL = ctrl;
      tick(1);
      TNET_CTRL = '0;
      tick(1);
   endtask

   task automatic clear_pulse();
      TNET_CTRL = 32'h80;
      tick(1);
      TNET_CTRL = '0;
      tick(2);
   endtask

   task automatic wait_state2(input string name);
      int n;
      n = 0;
      while (CMD_STATUS[13:12] != 2'd2 && n < 50) begin
         tick(1);
         n++;
      end
      chk(name, 133'(n >= 50), 133'(0));
   endtask

   task automatic done_pulse(input logic err);
      cmd_done_i = 1'b1;
      cmd_err_i  = err;
      tick(1);
      cmd_done_i = 1'b0;
      cmd_err_i  = 1'b0;
   endtask

   initial begin
      ps_aresetn = 1'b0;
      TNET_CTRL = '0; TNET_CFG = '0; TNET_ADDR = '0; TNET_LEN = '0;
      RAXI_DT1 = '0; RAXI_DT2 = '0; RAXI_DT3 = '0;
      cmd_ready_i = 1'b0; cmd_done_i = 1'b0; cmd_err_i = 1'b0;
      tick(3);
      cmp_on = 1'b1;
      chk("reset_status", 133'(CMD_STATUS), 133'(32'h0000_0002));
      chk("reset_valid", 133'(cmd_valid_o), 133'(0));
      ps_aresetn = 1'b1;
      tick(1);

      // Single command, ready tied high: valid for exactly one cycle at N+3.
      cmd_ready_i = 1'b1;
      TNET_ADDR = 16'h0012; TNET_LEN = 16'h0004; RAXI_DT1 = 32'hA5A5_A5A5;
      TNET_CTRL = 32'h7;
      tick(1);
      chk("lat_n1", 133'(cmd_valid_o), 133'(0));
      TNET_CTRL = '0;
      tick(1);
      chk("lat_n2", 133'(cmd_valid_o), 133'(0));
      tick(1);
      chk("lat_n3", 133'(cmd_valid_o), 133'(1));
      chk("lat_fields", {cmd_op_o, cmd_addr_o, cmd_len_o, cmd_dt_o},
          {5'd3, 16'h0012, 16'h0004, 64'h0, 32'hA5A5_A5A5});
      chk("issue_status", 133'(CMD_STATUS), 133'(32'h0000_1003));
      tick(1);
      chk("lat_n4", 133'(cmd_valid_o), 133'(0));
      chk("wait_status", 133'(CMD_STATUS), 133'(32'h0000_2003));
      tick(4);
      done_pulse(1'b0);
      chk("done1_status", 133'(CMD_STATUS), 133'(32'h0001_0002));

      // Queue fill with the core stalled, then one more to overflow.
      cmd_ready_i = 1'b0;
      for (int k = 1; k <= 5; k++) do_exec(32'((k << 1) | 1));
      chk("fill_status", 133'(CMD_STATUS), 133'(32'h0001_1025));
      chk("fill_head_op", 133'(cmd_op_o), 133'(1));
      do_exec(32'hD);
      chk("ovf_status", 133'(CMD_STATUS), 133'(32'h0001_1125));
      cmd_ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_state2("drain_wait");
         done_pulse(1'b0);
      end
      chk("drain_status", 133'(CMD_STATUS), 133'(32'h0006_0102));
      clear_pulse();
      chk("ovf_clear", 133'(CMD_STATUS), 133'(32'h0006_0002));

      do_exec(32'h1);
      chk("bad_op_set", 133'(CMD_STATUS), 133'(32'h0006_0802));
      clear_pulse();
      chk("bad_op_clear", 133'(CMD_STATUS), 133'(32'h0006_0002));

      // Core never completes; timeout of 10 cycles when built.
      TNET_CFG = 32'd10;
      TNET_CTRL = 32'h3;
      tick(1);
      TNET_CTRL = '0;
      tick(2);
      chk("to_issue", 133'(cmd_valid_o), 133'(1));
      tick(1);
      chk("to_enter", 133'(CMD_STATUS[13:12]), 133'(2));
      tick(9);
      chk("to_before", 133'({CMD_STATUS[13:12], CMD_STATUS[10]}), 133'(3'b100));
      tick(1);
`ifdef TNET_CMD_TIMEOUT_EN
      chk("to_expired", 133'(CMD_STATUS), 133'(32'h0006_0402));
      clear_pulse();
      dc = 6;
`else
      chk("to_stays_wait", 133'(CMD_STATUS), 133'(32'h0006_2003));
      done_pulse(1'b0);
      chk("to_done_exit", 133'(CMD_STATUS), 133'(32'h0007_0002));
      dc = 7;
`endif
      TNET_CFG = '0;

      do_exec(32'h9);
      wait_state2("err_wait");
      done_pulse(1'b1);
      dc++;
      chk("err_set", 133'(CMD_STATUS), 133'({dc[15:0], 16'h0202}));
      clear_pulse();
      chk("err_clear", 133'(CMD_STATUS[9]), 133'(0));

      // Error set lands in the same cycle as the clear rise.
      do_exec(32'hB);
      wait_state2("coinc_wait");
      TNET_CTRL = 32'h80;
      tick(1);
      done_pulse(1'b1);
      dc++;
      TNET_CTRL = '0;
      chk("err_set_wins", 133'(CMD_STATUS), 133'({dc[15:0], 16'h0202}));

      do_exec(32'hD);
      wait_state2("rst_wait");
      ps_aresetn = 1'b0;
      tick(1);
      ps_aresetn = 1'b1;
      chk("midrst_status", 133'(CMD_STATUS), 133'(32'h0000_0002));
      chk("midrst_valid", 133'(cmd_valid_o), 133'(0));
      done_pulse(1'b0);
      tick(1);
      chk("late_done", 133'(CMD_STATUS), 133'(32'h0000_0002));

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 1) == 0) begin
            rv = $urandom;
            rv[0] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rv[5:1] = 5'd0;
            rv[7] = ($urandom_range(0, 9) == 0);
            TNET_CTRL = rv;
         end
         TNET_ADDR = 16'($urandom);
         TNET_LEN  = 16'($urandom);
         RAXI_DT1  = $urandom;
         RAXI_DT2  = $urandom;
         RAXI_DT3  = $urandom;
         if ($urandom_range(0, 7) == 0) cmd_ready_i = 1'($urandom_range(0, 1));
         cmd_done_i = ($urandom_range(0, 5) == 0);
         cmd_err_i  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 31) == 0) begin
            rv = $urandom;
            rv[15:0] = 16'($urandom_range(0, 12));
            TNET_CFG = rv;
         end
         ps_aresetn = ($urandom_range(0, 599) != 0);
         tick(1);
      end
      ps_aresetn = 1'b1;
      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
